// File: rtl/ascon_aead128_pkg.sv
`default_nettype none
// ============================================================================
// ascon_aead128_pkg : shared Ascon types, round constants and S-box table
// Revision: 1.0
// ============================================================================
package ascon_aead128_pkg;

    localparam int MAX_ROUNDS = 16;
    localparam int P12_INIT   = 4;
    localparam int P8_INIT    = 8;

    typedef logic [4:0] round_cnt;

    typedef enum logic [1:0] {
        PERM_IDLE = 2'd0,
        PERM_RUN  = 2'd1,
        PERM_DONE = 2'd2
    } ascon_perm_state;

    typedef struct packed {
        logic [63:0] s0;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] s3;
        logic [63:0] s4;
    } ascon_state;

    localparam logic [4:0] S_BOX_TABLE [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    // Round index 0..15 of the 16-round schedule; p12 uses 4..15, p8 uses 8..15.
    function automatic logic [7:0] const_add(input round_cnt r);
        case (r)
            5'd0:    return 8'h3c;
            5'd1:    return 8'h2d;
            5'd2:    return 8'h1e;
            5'd3:    return 8'h0f;
            5'd4:    return 8'hf0;
            5'd5:    return 8'he1;
            5'd6:    return 8'hd2;
            5'd7:    return 8'hc3;
            5'd8:    return 8'hb4;
            5'd9:    return 8'ha5;
            5'd10:   return 8'h96;
            5'd11:   return 8'h87;
            5'd12:   return 8'h78;
            5'd13:   return 8'h69;
            5'd14:   return 8'h5a;
            5'd15:   return 8'h4b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [4:0] s_box(input logic [4:0] x);
        return S_BOX_TABLE[x];
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round.sv
`default_nettype none
// ============================================================================
// ascon_round : one combinational Ascon round (const add, S-box, diffusion)
// Revision: 1.0
// ============================================================================
module ascon_round
    import ascon_aead128_pkg::*;
#(
    parameter int SBOX_LUT = 1
) (
    input  ascon_state  state_i,
    input  logic [7:0]  rc_i,
    input  logic        en_i,
    output ascon_state  state_o
);

    ascon_state w_ca;
    ascon_state w_sb;
    ascon_state w_ld;

    always_comb begin
        w_ca          = state_i;
        w_ca.s2[7:0]  = state_i.s2[7:0] ^ rc_i;
    end

    generate
        if (SBOX_LUT != 0) begin : g_sbox_lut
            always_comb begin
                logic [4:0] w_col;
                logic [4:0] w_sub;
                w_sb  = '0;
                w_col = '0;
                w_sub = '0;
                for (int b = 0; b < 64; b++) begin
                    w_col = {w_ca.s0[b], w_ca.s1[b], w_ca.s2[b], w_ca.s3[b], w_ca.s4[b]};
                    w_sub = s_box(w_col);
                    w_sb.s0[b] = w_sub[4];
                    w_sb.s1[b] = w_sub[3];
                    w_sb.s2[b] = w_sub[2];
                    w_sb.s3[b] = w_sub[1];
                    w_sb.s4[b] = w_sub[0];
                end
            end
        end else begin : g_sbox_eq
            logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
            logic [63:0] w_c0, w_c1, w_c2, w_c3, w_c4;
            always_comb begin
                w_x0 = w_ca.s0 ^ w_ca.s4;
                w_x4 = w_ca.s4 ^ w_ca.s3;
                w_x2 = w_ca.s2 ^ w_ca.s1;
                w_x1 = w_ca.s1;
                w_x3 = w_ca.s3;
                // chi-like core, then the output mixing of the bitsliced S-box
                w_c0 = w_x0 ^ (~w_x1 & w_x2);
                w_c1 = w_x1 ^ (~w_x2 & w_x3);
                w_c2 = w_x2 ^ (~w_x3 & w_x4);
                w_c3 = w_x3 ^ (~w_x4 & w_x0);
                w_c4 = w_x4 ^ (~w_x0 & w_x1);
                w_sb.s0 = w_c0 ^ w_c4;
                w_sb.s1 = w_c1 ^ w_c0;
                w_sb.s2 = ~w_c2;
                w_sb.s3 = w_c3 ^ w_c2;
                w_sb.s4 = w_c4;
            end
        end
    endgenerate

    always_comb begin
        w_ld.s0 = w_sb.s0 ^ ror64(w_sb.s0, 19) ^ ror64(w_sb.s0, 28);
        w_ld.s1 = w_sb.s1 ^ ror64(w_sb.s1, 61) ^ ror64(w_sb.s1, 39);
        w_ld.s2 = w_sb.s2 ^ ror64(w_sb.s2, 1)  ^ ror64(w_sb.s2, 6);
        w_ld.s3 = w_sb.s3 ^ ror64(w_sb.s3, 10) ^ ror64(w_sb.s3, 17);
        w_ld.s4 = w_sb.s4 ^ ror64(w_sb.s4, 7)  ^ ror64(w_sb.s4, 41);
    end

    assign state_o = en_i ? w_ld : state_i;

endmodule
`default_nettype wire

// File: rtl/ascon_perm_core.sv
`default_nettype none
// ============================================================================
// ascon_perm_core : Ascon p[n] engine, UNROLL rounds per clock, valid/ready I/O
// Revision: 1.0
// ============================================================================
module ascon_perm_core
    import ascon_aead128_pkg::*;
#(
    parameter int UNROLL   = 1,
    parameter int SBOX_LUT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  ascon_state  state_in,
    input  logic [4:0]  nrounds_in,
    output logic        out_valid,
    input  logic        out_ready,
    output ascon_state  state_out,
    output logic        busy
);

    generate
        if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
            $error("ascon_perm_core: UNROLL must be in 1..4");
        end
    endgenerate

    ascon_perm_state fsm_q, fsm_d;
    ascon_state      state_q, state_d;
    ascon_state      state_out_q, state_out_d;
    round_cnt        idx_q, idx_d;
    round_cnt        rem_q, rem_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    ascon_state      w_stage [UNROLL+1];
    logic            w_en    [UNROLL];
    logic [7:0]      w_rc    [UNROLL];
    round_cnt        w_k;
    round_cnt        w_nsat;

    assign w_stage[0] = state_q;

    // Stages beyond the remaining round count bypass, so const_add never sees idx >= 16.
    generate
        for (genvar j = 0; j < UNROLL; j++) begin : g_stage
            round_cnt w_ridx;
            assign w_ridx  = idx_q + round_cnt'(j);
            assign w_en[j] = (round_cnt'(j) < rem_q);
            assign w_rc[j] = w_en[j] ? const_add(w_ridx) : 8'h00;

            ascon_round #(
                .SBOX_LUT (SBOX_LUT)
            ) u_round (
                .state_i (w_stage[j]),
                .rc_i    (w_rc[j]),
                .en_i    (w_en[j]),
                .state_o (w_stage[j+1])
            );
        end
    endgenerate

    assign w_k    = (rem_q > round_cnt'(UNROLL)) ? round_cnt'(UNROLL) : rem_q;
    assign w_nsat = (nrounds_in > round_cnt'(MAX_ROUNDS)) ? round_cnt'(MAX_ROUNDS) : nrounds_in;

    assign in_ready  = (fsm_q == PERM_IDLE) || ((fsm_q == PERM_DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign state_out = state_out_q;
    assign busy      = busy_q;

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        state_out_d = state_out_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;

        case (fsm_q)
            PERM_RUN: begin
                state_d = w_stage[UNROLL];
                idx_d   = idx_q + w_k;
                rem_d   = rem_q - w_k;
                if (rem_q == w_k) begin
                    fsm_d       = PERM_DONE;
                    out_valid_d = 1'b1;
                    state_out_d = w_stage[UNROLL];
                end
            end
            PERM_DONE: begin
                if (out_ready) begin
                    fsm_d       = PERM_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                fsm_d = PERM_IDLE;
            end
        endcase

        // A zero-round job still spends one all-bypass cycle in PERM_RUN,
        // which gives every job a minimum latency of one clock.
        if (in_valid && in_ready) begin
            state_d = state_in;
            idx_d   = round_cnt'(MAX_ROUNDS) - w_nsat;
            rem_d   = w_nsat;
            fsm_d   = PERM_RUN;
        end

        busy_d = (fsm_d == PERM_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= PERM_IDLE;
            state_q     <= '0;
            state_out_q <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            state_out_q <= state_out_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_core.sv
`default_nettype none
// ============================================================================
// tb_ascon_perm_core : scoreboard bench over UNROLL=1..4 with both S-box styles
// Revision: 1.0
// ============================================================================
module tb_ascon_perm_core;

    localparam int NDUT = 4;
    localparam int TIMEOUT = 200;
    localparam logic [4:0] SBOX_REF [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic         clk;
    logic         rst;
    logic         in_valid   [NDUT];
    logic         in_ready   [NDUT];
    logic [319:0] state_in   [NDUT];
    logic [4:0]   nrounds_in [NDUT];
    logic         out_valid  [NDUT];
    logic         out_ready  [NDUT];
    logic [319:0] state_out  [NDUT];
    logic         busy       [NDUT];

    int checks   = 0;
    int failures = 0;
    logic [319:0] exp_q [$];

    // Instance g has UNROLL=g+1; S-box style alternates between table and equations.
    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            ascon_perm_core #(
                .UNROLL   (g + 1),
                .SBOX_LUT ((g % 2 == 0) ? 1 : 0)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid[g]),
                .in_ready   (in_ready[g]),
                .state_in   (state_in[g]),
                .nrounds_in (nrounds_in[g]),
                .out_valid  (out_valid[g]),
                .out_ready  (out_ready[g]),
                .state_out  (state_out[g]),
                .busy       (busy[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int n_in);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  sub;
        logic [7:0]  c;
        int          n;
        n = (n_in > 16) ? 16 : n_in;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = 16 - n; r < 16; r++) begin
            c = {4'(19 - r), 4'(r + 12)};
            x[2] = x[2] ^ {56'h0, c};
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                sub = SBOX_REF[col];
                for (int i = 0; i < 5; i++) y[i][b] = sub[4 - i];
            end
            x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
            x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
            x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
            x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
            x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accept edge until out_valid rises (bounded).
    task automatic wait_out(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < TIMEOUT) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_job(input int d, input logic [319:0] st, input logic [4:0] n,
                           input int exp_lat, input string name);
        logic [319:0] exp_s;
        int lat;
        state_in[d]   = st;
        nrounds_in[d] = n;
        in_valid[d]   = 1'b1;
        checks++;
        if (in_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready[d]);
        end
        tick();
        in_valid[d] = 1'b0;
        exp_q.push_back(model_perm(st, int'(n)));
        wait_out(d, lat);
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (state_out[d] !== exp_s) begin
            failures++;
            $display("FAIL %s state_out: got %h want %h", name, state_out[d], exp_s);
        end
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        checks++;
        if (out_valid[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s out_valid after transfer: got %b want 0", name, out_valid[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            checks += 4;
            if (in_ready[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset in_ready[%0d]: got %b want 1", d, in_ready[d]);
            end
            if (out_valid[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset out_valid[%0d]: got %b want 0", d, out_valid[d]);
            end
            if (busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset busy[%0d]: got %b want 0", d, busy[d]);
            end
            if (state_out[d] !== 320'h0) begin
                failures++;
                $display("FAIL reset state_out[%0d]: got %h want 0", d, state_out[d]);
            end
        end
    endtask

    task automatic test_p12_p8();
        logic [319:0] iv_state;
        iv_state = {64'h80400c0600000000, 256'h0};
        run_job(0, iv_state, 5'd12, 12, "p12_u1");
        run_job(2, iv_state, 5'd8, 3, "p8_u3");
        run_job(1, iv_state, 5'd8, 4, "p8_u2");
        run_job(3, rand_state(), 5'd6, 2, "p6_u4");
        run_job(2, rand_state(), 5'd1, 1, "p1_u3");
    endtask

    task automatic test_zero_and_sat();
        logic [319:0] r;
        r = rand_state();
        run_job(0, r, 5'd0, 1, "p0_u1");
        checks++;
        if (state_out[0] !== r) begin
            failures++;
            $display("FAIL p0 identity: got %h want %h", state_out[0], r);
        end
        run_job(1, r, 5'd20, 8, "p20_u2");
        run_job(3, r, 5'd31, 4, "p31_u4");
        run_job(3, r, 5'd16, 4, "p16_u4");
    endtask

    task automatic test_back_to_back();
        logic [319:0] a, b, exp_s;
        int lat;
        a = rand_state();
        b = rand_state();
        out_ready[3]  = 1'b1;
        state_in[3]   = a;
        nrounds_in[3] = 5'd6;
        in_valid[3]   = 1'b1;
        tick();
        exp_q.push_back(model_perm(a, 6));
        state_in[3]   = b;
        nrounds_in[3] = 5'd12;
        exp_q.push_back(model_perm(b, 12));
        wait_out(3, lat);
        checks += 3;
        if (lat != 2) begin
            failures++;
            $display("FAIL b2b A latency: got %0d want 2", lat);
        end
        if (in_ready[3] !== 1'b1) begin
            failures++;
            $display("FAIL b2b in_ready at handoff: got %b want 1", in_ready[3]);
        end
        exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (state_out[3] !== exp_s) begin
            failures++;
            $display("FAIL b2b A state_out: got %h want %h", state_out[3], exp_s);
        end
        tick();
        in_valid[3] = 1'b0;
        checks += 2;
        if (busy[3] !== 1'b1) begin
            failures++;
            $display("FAIL b2b B not accepted at handoff: busy got %b want 1", busy[3]);
        end
        if (out_valid[3] !== 1'b0) begin
            failures++;
            $display("FAIL b2b out_valid after A: got %b want 0", out_valid[3]);
        end
        wait_out(3, lat);
        checks += 2;
        if (lat != 3) begin
            failures++;
            $display("FAIL b2b B latency: got %0d want 3", lat);
        end
        exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (state_out[3] !== exp_s) begin
            failures++;
            $display("FAIL b2b B state_out: got %h want %h", state_out[3], exp_s);
        end
        tick();
        out_ready[3] = 1'b0;
        checks++;
        if (out_valid[3] !== 1'b0) begin
            failures++;
            $display("FAIL b2b out_valid after B: got %b want 0", out_valid[3]);
        end
    endtask

    task automatic test_backpressure();
        logic [319:0] s, exp_s;
        int lat;
        s = rand_state();
        state_in[1]   = s;
        nrounds_in[1] = 5'd12;
        in_valid[1]   = 1'b1;
        tick();
        exp_q.push_back(model_perm(s, 12));
        in_valid[1] = 1'b0;
        wait_out(1, lat);
        exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (lat != 6) begin
            failures++;
            $display("FAIL stall latency: got %0d want 6", lat);
        end
        state_in[1]   = rand_state();
        nrounds_in[1] = 5'd3;
        in_valid[1]   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks += 3;
            if (out_valid[1] !== 1'b1) begin
                failures++;
                $display("FAIL stall out_valid cyc%0d: got %b want 1", i, out_valid[1]);
            end
            if (in_ready[1] !== 1'b0) begin
                failures++;
                $display("FAIL stall in_ready cyc%0d: got %b want 0", i, in_ready[1]);
            end
            if (state_out[1] !== exp_s) begin
                failures++;
                $display("FAIL stall state_out cyc%0d: got %h want %h", i, state_out[1], exp_s);
            end
            tick();
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        tick();
        out_ready[1] = 1'b0;
        checks += 2;
        if (out_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL stall release out_valid: got %b want 0", out_valid[1]);
        end
        if (in_ready[1] !== 1'b1) begin
            failures++;
            $display("FAIL stall release in_ready: got %b want 1", in_ready[1]);
        end
        repeat (2) tick();
        checks += 2;
        if (out_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL stall single transfer: out_valid got %b want 0", out_valid[1]);
        end
        if (busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL stall ignored job: busy got %b want 0", busy[1]);
        end
    endtask

    task automatic test_reset_midrun();
        state_in[0]   = rand_state();
        nrounds_in[0] = 5'd12;
        in_valid[0]   = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 4;
        if (out_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL midrst out_valid: got %b want 0", out_valid[0]);
        end
        if (in_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrst in_ready: got %b want 1", in_ready[0]);
        end
        if (state_out[0] !== 320'h0) begin
            failures++;
            $display("FAIL midrst state_out: got %h want 0", state_out[0]);
        end
        if (busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL midrst busy: got %b want 0", busy[0]);
        end
        repeat (14) tick();
        checks++;
        if (out_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL midrst late out_valid: got %b want 0", out_valid[0]);
        end
        run_job(0, rand_state(), 5'd5, 5, "after_rst_u1");
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d]   = 1'b0;
            out_ready[d]  = 1'b0;
            state_in[d]   = '0;
            nrounds_in[d] = '0;
        end
        test_reset();
        test_p12_p8();
        test_zero_and_sat();
        test_back_to_back();
        test_backpressure();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
